uart_tx_port: RTL and testbench
===============================

Name: uart_tx_port

Overview:
- Serial transmit side of the CPU's RS-232 I/O device.
- The CPU issues an IO write to device address 1 (writeTX), presenting TXchar = register A[7:0]. It polls TXempty via the skip-on-InReady path before each write.
- The block serialises each accepted byte as 8N1 on TxD at a fixed baud rate derived from the 50 MHz Clock.

Parameters:
- CLK_HZ, 50000000, Clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DIVISOR, CLK_HZ/BAUD (434 at defaults), Clock cycles per bit. Integer division, truncated. Must be >= 2.
- FIFO_DEPTH, 4, entries in the optional holding FIFO. Power of two; used only with UART_TX_FIFO_EN.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  reset.
- writeTX  input  1  single-cycle write strobe from the CPU IO decode.
- TXchar  input  8  byte to send; sampled on the cycle writeTX=1.
- TXempty  output  1  1 = block can accept a write this cycle.
- TxD  output  1  serial line; idle high.
- Interface: reset Reset, synchronous, active-high; clock Clock.

Behaviour:
- Reset (any cycle, including mid-frame):
  - At the next Clock edge: TxD=1, TXempty=1, state=IDLE, baud and bit counters=0.
  - Any frame in progress is aborted; no partial stop bit is sent.
- FSM: IDLE -> START -> DATA -> STOP -> IDLE, or STOP -> START when another byte is pending.
  - IDLE: TxD=1. Accepted byte loaded into shift register; go to START.
  - START: TxD=0 for DIVISOR cycles.
  - DATA: TxD=shift[0] for DIVISOR cycles per bit, LSB first. After 8 bits go to STOP.
  - STOP: TxD=1 for DIVISOR cycles. Then go to IDLE, or straight to START if another byte is available (no idle gap).
- Counters:
  - Baud counter width = clog2(DIVISOR). Counts 0..DIVISOR-1 and clears when entering START.
  - Bit-time end = counter reaches DIVISOR-1.
  - Bit counter: 3 bits, wraps 7->0 on the transition to STOP.
- Accept rule: a write is accepted iff writeTX=1 and TXempty=1 on the same edge. Writes with TXempty=0 are silently dropped; there is no error flag.
- Latency, base build:
  - Accepted write at edge N -> TxD=0 and TXempty=0 from edge N+1.
  - Frame lasts 10*DIVISOR cycles.
  - TXempty returns to 1 on the edge that ends the stop bit.
- TxD is registered, so it has no glitches.
- TXchar is ignored whenever writeTX=0.

Optional Feature:
- Macro: UART_TX_FIFO_EN.
- Defined:
  - A FIFO_DEPTH-entry FIFO sits in front of the shifter. TXempty = FIFO not full.
  - A write to a full FIFO is dropped.
  - The shifter pops at IDLE, or at the end of STOP when the FIFO is non-empty.
  - A write and a pop on the same edge are both honoured; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty detection.
- Undefined: single-byte behaviour exactly as in Behaviour.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, STOP).
  - Function computing DIVISOR and baud counter width.
  - Constants DATA_BITS=8 and STOP_LEVEL=1.
- Sub-module uart_baud_gen:
  - Inputs: Clock, Reset, clear.
  - Output: tick, high on the last cycle of each bit period.
  - Reused later by the receive side.

Test Plan (DIVISOR=16 unless noted):
- Reset, then idle 50 cycles -> TxD=1 and TXempty=1 throughout.
- Write 0x55 at edge 0 -> TxD=0 for cycles 1-16, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then stop=1 for cycles 145-160. TXempty=0 for cycles 1-160 and 1 at 161.
- Write 0xA3 while busy (edge 40), base build -> dropped; the line carries only the first byte; the next frame starts only after a new write.
- Reset asserted at cycle 70 of a frame carrying 0x00 -> TxD=1 and TXempty=1 at edge 71. A subsequent write of 0x0F produces a clean, full frame.
- UART_TX_FIFO_EN, FIFO_DEPTH=4: write 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive edges.
  - 0x01 is popped into the shifter one edge after its write. 0x02-0x05 then fill the FIFO.
  - TXempty falls after 0x05 is accepted.
  - Frames 0x01, 0x02, 0x03, 0x04, 0x05 go out back-to-back, each start bit immediately after the previous stop bit.
- Default parameters (DIVISOR=434) -> measured bit period is exactly 434 cycles; the 0x55 frame lasts 4340 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, constants and sizing helpers for the UART transmit
// and receive sides.
package uart_pkg;

   // Transmit frame sequencer states
   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam int   DATA_BITS  = 8;
   localparam logic STOP_LEVEL = 1'b1;

   // Clock cycles per bit; integer division truncates toward zero
   function automatic int calcDivisor(input int clkHz, input int baud);
      return clkHz / baud;
   endfunction

   // Baud counter width; never narrower than one bit
   function automatic int calcCountWidth(input int divisor);
      return (divisor <= 2) ? 1 : $clog2(divisor);
   endfunction

endpackage

// File: rtl/uart_tx_port_if.sv
// uart_tx_port_if: CPU-side write handshake plus the serial line of the
// transmit port. The CPU is the master; the transmitter is the slave.
interface uart_tx_port_if;

   logic                          writeTX;
   logic [uart_pkg::DATA_BITS-1:0] TXchar;
   logic                          TXempty;
   logic                          TxD;

   modport master (
      output writeTX,
      output TXchar,
      input  TXempty,
      input  TxD
   );

   modport slave (
      input  writeTX,
      input  TXchar,
      output TXempty,
      output TxD
   );

endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running bit-period counter. o_tick marks the last cycle
// of each bit period; i_clear restarts the period so a frame begins aligned.
// Shared by the transmit and receive sides.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int DIVISOR = 434
)
(
   input  logic Clock,
   input  logic Reset,
   input  logic i_clear,
   output logic o_tick
);

   localparam int                CNT_W = calcCountWidth(DIVISOR);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIVISOR - 1);

   logic [CNT_W-1:0] r_count;

   // Count 0..DIVISOR-1, restarting on clear or at the end of each period
   always_ff @(posedge Clock) begin
      if (Reset || i_clear) begin
         r_count <= '0;
      end else if (r_count == LAST) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_tick = (r_count == LAST);

endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: 8N1 serial transmitter for the CPU's RS-232 IO device.
// Build option UART_TX_FIFO_EN: adds a FIFO_DEPTH-entry holding FIFO in front
// of the shifter; without it a single byte is buffered and writes made while
// busy are dropped.
module uart_tx_port
   import uart_pkg::*;
#(
   parameter int CLK_HZ  = 50000000,
   parameter int BAUD    = 115200,
   parameter int DIVISOR = calcDivisor(CLK_HZ, BAUD)
`ifdef UART_TX_FIFO_EN
   ,parameter int FIFO_DEPTH = 4
`endif
)
(
   input  logic          Clock,
   input  logic          Reset,
   uart_tx_port_if.slave bus
);

   localparam int              BIT_W    = $clog2(DATA_BITS);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

   tx_state_t            r_state;
   logic [DATA_BITS-1:0] r_shift;
   logic [BIT_W-1:0]     r_bitCnt;
   logic                 r_txd;

   logic                 w_tick;
   logic                 w_accept;
   logic                 w_avail;
   logic                 w_pop;
   logic                 w_txEmpty;
   logic [DATA_BITS-1:0] w_nextByte;

   assign w_accept = bus.writeTX && w_txEmpty;

   // A byte is taken into the shifter from IDLE, or at the end of a stop bit
   // so the next start bit follows with no idle gap. Every pop enters START.
   assign w_pop = w_avail &&
                  ((r_state == IDLE) || ((r_state == STOP) && w_tick));

   uart_baud_gen #(
      .DIVISOR (DIVISOR)
   ) u_baudGen (
      .Clock   (Clock),
      .Reset   (Reset),
      .i_clear (w_pop),
      .o_tick  (w_tick)
   );

`ifdef UART_TX_FIFO_EN
   localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_BITS-1:0] r_fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0]     r_wrPtr;
   logic [PTR_W-1:0]     r_rdPtr;
   logic                 w_full;
   logic                 w_empty;

   assign w_empty    = (r_wrPtr == r_rdPtr);
   assign w_full     = (r_wrPtr[PTR_W-1] != r_rdPtr[PTR_W-1]) &&
                       (r_wrPtr[PTR_W-2:0] == r_rdPtr[PTR_W-2:0]);
   assign w_txEmpty  = !w_full;
   assign w_avail    = !w_empty;
   assign w_nextByte = r_fifoMem[r_rdPtr[PTR_W-2:0]];

   // Holding FIFO; a write and a pop on the same edge are both honoured
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_accept) begin
            r_fifoMem[r_wrPtr[PTR_W-2:0]] <= bus.TXchar;
            r_wrPtr                       <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
      end
   end
`else
   logic                 r_holdValid;
   logic [DATA_BITS-1:0] r_holdData;
   logic                 r_txEmpty;

   assign w_txEmpty  = r_txEmpty;
   assign w_avail    = r_holdValid;
   assign w_nextByte = r_holdData;

   // Single-byte buffer; the port stays busy from acceptance to the end of
   // the stop bit, so writes during a frame are ignored
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_holdValid <= 1'b0;
         r_holdData  <= '0;
         r_txEmpty   <= 1'b1;
      end else if (w_accept) begin
         r_holdValid <= 1'b1;
         r_holdData  <= bus.TXchar;
         r_txEmpty   <= 1'b0;
      end else if (w_pop) begin
         r_holdValid <= 1'b0;
      end else if ((r_state == STOP) && w_tick) begin
         r_txEmpty   <= 1'b1;
      end
   end
`endif

   // Frame sequencer with a registered line output
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state  <= IDLE;
         r_shift  <= '0;
         r_bitCnt <= '0;
         r_txd    <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               r_txd <= 1'b1;
               if (w_pop) begin
                  r_shift  <= w_nextByte;
                  r_bitCnt <= '0;
                  r_txd    <= 1'b0;
                  r_state  <= START;
               end
            end
            START: begin
               if (w_tick) begin
                  r_txd   <= r_shift[0];
                  r_state <= DATA;
               end
            end
            DATA: begin
               if (w_tick) begin
                  r_bitCnt <= r_bitCnt + BIT_W'(1);
                  if (r_bitCnt == LAST_BIT) begin
                     r_txd   <= STOP_LEVEL;
                     r_state <= STOP;
                  end else begin
                     r_shift <= r_shift >> 1;
                     r_txd   <= r_shift[1];
                  end
               end
            end
            STOP: begin
               if (w_tick) begin
                  if (w_pop) begin
                     r_shift  <= w_nextByte;
                     r_bitCnt <= '0;
                     r_txd    <= 1'b0;
                     r_state  <= START;
                  end else begin
                     r_txd    <= 1'b1;
                     r_state  <= IDLE;
                  end
               end
            end
            default: begin
               r_txd   <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.TxD     = r_txd;
   assign bus.TXempty = w_txEmpty;

endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: scoreboard bench for uart_tx_port. A line monitor decodes
// frames from TxD and compares them against bytes queued when writes are
// driven. Also exercises a default-parameter instance for bit timing.
module tb_uart_tx_port;

   localparam int DIV = 16;
   localparam int DEF_DIV = 434;
`ifdef UART_TX_FIFO_EN
   localparam bit FIFO_BUILD = 1'b1;
`else
   localparam bit FIFO_BUILD = 1'b0;
`endif

   logic Clock;
   logic Reset;
   int   cycle;
   int   checks;
   int   failures;

   logic [7:0] expQ[$];
   int         frameStarts[$];
   logic [7:0] monData;
   logic [7:0] monExp;
   int         monStart;
   bit         monAborted;

   uart_tx_port_if bus ();
   uart_tx_port_if bus434 ();

   uart_tx_port #(
      .DIVISOR (DIV)
   ) u_dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   uart_tx_port u_dut434 (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus434)
   );

   // Free-running clock
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Edge counter used to timestamp frame starts
   always @(posedge Clock) begin
      cycle <= cycle + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one write strobe sampled on the next rising edge
   task automatic applyStimulus(input logic [7:0] b, input bit expectAccept);
      bus.writeTX = 1'b1;
      bus.TXchar  = b;
      if (expectAccept) expQ.push_back(b);
      @(posedge Clock);
      #1;
      bus.writeTX = 1'b0;
      bus.TXchar  = 8'($urandom);
   endtask

   task automatic drainWait(input int budget);
      int waited;
      waited = 0;
      while (expQ.size() != 0 && waited < budget) begin
         @(negedge Clock);
         waited++;
      end
      checkOutput("drain_timeout", expQ.size(), 0);
      repeat (4) @(negedge Clock);
      checkOutput("drain_txempty", bus.TXempty, 1);
   endtask

   function automatic logic expTxd(input int c, input logic [7:0] b);
      if (c < 1) return 1'b1;
      if (c <= DIV) return 1'b0;
      if (c <= 9 * DIV) return b[(c - DIV - 1) / DIV];
      return 1'b1;
   endfunction

   // Line monitor: decode each frame mid-bit and score it
   initial begin
      forever begin
         @(negedge Clock);
         if (!Reset && bus.TxD === 1'b0) begin
            monStart   = cycle;
            monData    = '0;
            monAborted = 1'b0;
            for (int c = 1; c < 10 * DIV; c++) begin
               @(negedge Clock);
               if (Reset) begin
                  monAborted = 1'b1;
                  break;
               end
               if (c % DIV == DIV / 2) begin
                  if (c / DIV == 0) checkOutput("start_bit", bus.TxD, 0);
                  else if (c / DIV <= 8) monData[c / DIV - 1] = bus.TxD;
                  else checkOutput("stop_bit", bus.TxD, 1);
               end
            end
            if (!monAborted) begin
               frameStarts.push_back(monStart);
               checkOutput("sb_pending", expQ.size() != 0, 1);
               if (expQ.size() != 0) begin
                  monExp = expQ.pop_front();
                  checkOutput("frame_data", monData, monExp);
               end
            end
         end
      end
   end

   // Main test sequence
   initial begin
      int runLen;
      int runIdx;
      int guard;
      int total;
      logic level;

      checks         = 0;
      failures       = 0;
      cycle          = 0;
      Reset          = 1'b1;
      bus.writeTX    = 1'b0;
      bus.TXchar     = '0;
      bus434.writeTX = 1'b0;
      bus434.TXchar  = '0;
      repeat (3) @(posedge Clock);
      #1;
      Reset = 1'b0;

      // Idle after reset
      for (int c = 0; c < 50; c++) begin
         @(negedge Clock);
         checkOutput("idle_txd", bus.TxD, 1);
         checkOutput("idle_txempty", bus.TXempty, 1);
      end

      // 0x55 frame, cycle-exact, with a write of 0xA3 at edge 40
      applyStimulus(8'h55, 1'b1);
      for (int c = 0; c <= 10 * DIV + 1; c++) begin
         @(negedge Clock);
         if (c >= 1 && c <= 10 * DIV)
            checkOutput($sformatf("f55_txd_c%0d", c), bus.TxD, expTxd(c, 8'h55));
         if (c >= 1)
            checkOutput($sformatf("f55_txempty_c%0d", c), bus.TXempty,
                        (c <= 10 * DIV) ? FIFO_BUILD : 1'b1);
         if (c == 39) begin
            bus.writeTX = 1'b1;
            bus.TXchar  = 8'hA3;
            if (FIFO_BUILD) expQ.push_back(8'hA3);
         end
         if (c == 40) bus.writeTX = 1'b0;
      end
      drainWait(4 * 10 * DIV);
      repeat (200) @(negedge Clock);
      checkOutput("drop_frames", frameStarts.size(), FIFO_BUILD ? 2 : 1);
`ifdef UART_TX_FIFO_EN
      checkOutput("a3_backtoback", frameStarts[1] - frameStarts[0], 10 * DIV);
`endif
      frameStarts.delete();

      // Reset in the middle of a 0x00 frame
      applyStimulus(8'h00, 1'b0);
      for (int c = 0; c <= 71; c++) begin
         @(negedge Clock);
         if (c == 70) begin
            checkOutput("pre_reset_txd", bus.TxD, 0);
            Reset = 1'b1;
         end
         if (c == 71) begin
            checkOutput("reset_txd", bus.TxD, 1);
            checkOutput("reset_txempty", bus.TXempty, 1);
            Reset = 1'b0;
         end
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge Clock);
         checkOutput("post_reset_idle", bus.TxD, 1);
      end
      checkOutput("aborted_not_scored", frameStarts.size(), 0);
      applyStimulus(8'h0F, 1'b1);
      drainWait(2 * 10 * DIV);
      checkOutput("clean_frame", frameStarts.size(), 1);
      frameStarts.delete();

`ifdef UART_TX_FIFO_EN
      // Five consecutive writes into the FIFO
      for (int i = 0; i < 5; i++) begin
         bus.writeTX = 1'b1;
         bus.TXchar  = 8'(i + 1);
         expQ.push_back(8'(i + 1));
         @(posedge Clock);
         #1;
         checkOutput($sformatf("fifo_txempty_%0d", i), bus.TXempty, (i < 4) ? 1 : 0);
         if (i == 1) checkOutput("fifo_first_start", bus.TxD, 0);
      end
      bus.writeTX = 1'b0;
      drainWait(6 * 10 * DIV);
      checkOutput("fifo_frames", frameStarts.size(), 5);
      for (int i = 1; i < frameStarts.size(); i++)
         checkOutput($sformatf("fifo_gap_%0d", i), frameStarts[i] - frameStarts[i - 1], 10 * DIV);
`endif

      // Default divisor: measure every run of the 0x55 frame
      bus434.writeTX = 1'b1;
      bus434.TXchar  = 8'h55;
      @(posedge Clock);
      #1;
      bus434.writeTX = 1'b0;
      guard = 0;
      do begin
         @(negedge Clock);
         guard++;
      end while (bus434.TxD !== 1'b0 && guard < 10);
      checkOutput("b434_start_seen", bus434.TxD, 0);
      checkOutput("b434_start_latency", guard, 2);
      runLen = 1;
      runIdx = 0;
      total  = 1;
      level  = 1'b0;
      while (runIdx < 9 && guard < 6000) begin
         @(negedge Clock);
         guard++;
         total++;
         if (bus434.TxD == level) begin
            runLen++;
         end else begin
            checkOutput($sformatf("b434_run%0d", runIdx), runLen, DEF_DIV);
            runIdx++;
            level  = ~level;
            runLen = 1;
         end
      end
      checkOutput("b434_runs", runIdx, 9);
`ifndef UART_TX_FIFO_EN
      while (bus434.TXempty == 1'b0 && guard < 6000) begin
         @(negedge Clock);
         guard++;
         total++;
      end
      checkOutput("b434_frame_len", total - 1, 10 * DEF_DIV);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
